multicycle_control: RTL

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM (fetch/decode/mem/exec/branch/jump).
// Optional build macro MULTICYCLE_JUMP_EN enables the JUMP state for opcode 000010.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcB,
  output logic       IllegalOp,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

`ifdef MULTICYCLE_JUMP_EN
  localparam logic JUMP_EN = 1'b1;
`else
  localparam logic JUMP_EN = 1'b0;
`endif

  state_t state;
  state_t state_next;
  logic   op_illegal;

  always_comb begin
    state_next = FETCH;
    op_illegal = 1'b0;
    case (state)
      FETCH:  state_next = MemReady ? DECODE : FETCH;
      DECODE: begin
        if (Op == OP_LW || Op == OP_SW) begin
          state_next = MEMADR;
        end else if (Op == OP_RTYPE) begin
          state_next = EXEC;
        end else if (Op == OP_BEQ) begin
          state_next = BRANCH;
        end else if (Op == OP_J && JUMP_EN) begin
          state_next = JUMP;
        end else begin
          state_next = FETCH;
          op_illegal = 1'b1;
        end
      end
      // An opcode that changed to neither lw nor sw here is abandoned back to FETCH.
      MEMADR: begin
        if (Op == OP_LW)      state_next = MEMRD;
        else if (Op == OP_SW) state_next = MEMWR;
        else                  state_next = FETCH;
      end
      MEMRD:  state_next = MemReady ? MEMWB : MEMRD;
      MEMWR:  state_next = MemReady ? FETCH : MEMWR;
      EXEC:   state_next = RWB;
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = '0;
    ALUOp       = '0;
    ALUSrcB     = '0;
    case (state)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = MemReady;
        PCWrite = MemReady;
      end
      DECODE: ALUSrcB = 2'b11;
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      default: ;
    endcase
    // Strobes that change architectural state are suppressed during reset.
    if (reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
    end
  end

  assign IllegalOp = (state == DECODE) && op_illegal && !reset;
  assign State     = state;

endmodule
